// File: rtl/shift_rows_pipe_if.sv
// Handshake bundle for shift_rows_pipe: block input and block output.
// master = producer/consumer side, slave = the pipe itself.
interface shift_rows_pipe_if #(
    parameter int NB = 4
) ();
    localparam int W = 32 * NB;

    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_inv;
    logic [W-1:0] out_data;

    modport master (
        output in_valid,
        output in_inv,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_inv,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_inv,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_inv,
        output out_data
    );
endinterface

// File: rtl/shift_rows_pipe.sv
// Rijndael (Inv)ShiftRows applied on input, then a 2-entry FIFO.
// Ports: clk, rst_n (async low), flush (sync clear), bus (slave).
module shift_rows_pipe #(
    parameter int NB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    shift_rows_pipe_if.slave bus
);
    localparam int W = 32 * NB;

    typedef struct packed {
        logic         inv;
        logic [W-1:0] data;
    } entry_t;

    // Rows 2 and 3 shift one further for the 256-bit block.
    function automatic int row_shift(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic logic [W-1:0] shift_rows(
        input logic [W-1:0] d,
        input logic         inv
    );
        logic [W-1:0] o;
        int           src;
        o   = '0;
        src = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NB; c++) begin
                if (inv)
                    src = (c + NB - row_shift(r)) % NB;
                else
                    src = (c + row_shift(r)) % NB;
                o[8*(4*c+r) +: 8] = d[8*(4*src+r) +: 8];
            end
        end
        return o;
    endfunction

    entry_t     mem_q [2];
    entry_t     wr_entry;
    logic       rd_q;
    logic       rd_d;
    logic       wr_q;
    logic       wr_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       rdy_q;
    logic       push;
    logic       pop;

    // rdy_q holds in_ready low until the first edge after reset.
    assign bus.in_ready  = rdy_q && (cnt_q < 2'd2) && !flush;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_inv   = mem_q[rd_q].inv;
    assign bus.out_data  = mem_q[rd_q].data;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign wr_entry.inv  = bus.in_inv;
    assign wr_entry.data = shift_rows(bus.in_data, bus.in_inv);

    always_comb begin
        cnt_d = cnt_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (flush) begin
            cnt_d = '0;
            rd_d  = 1'b0;
            wr_d  = 1'b0;
        end else begin
            if (push)
                wr_d = ~wr_q;
            if (pop)
                rd_d = ~rd_q;
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            rdy_q <= 1'b0;
            for (int i = 0; i < 2; i++)
                mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            rdy_q <= 1'b1;
            // push already excludes flush through in_ready
            if (push)
                mem_q[wr_q] <= wr_entry;
        end
    end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed + random bench for shift_rows_pipe (NB=4 and NB=8).
// Reference: byte-matrix ShiftRows model and a queue scoreboard.
module tb_shift_rows_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   compared = 0;
    int   mism     = 0;

    typedef struct {
        logic         inv;
        logic [127:0] data;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    shift_rows_pipe_if #(.NB(4)) bus4 ();
    shift_rows_pipe_if #(.NB(8)) bus8 ();

    shift_rows_pipe #(.NB(4)) u4 (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus4.slave)
    );

    shift_rows_pipe #(.NB(8)) u8 (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus8.slave)
    );

    function automatic logic [255:0] ref_shift(
        input logic [255:0] d,
        input logic         inv,
        input int           nb
    );
        logic [7:0]   st [4][8];
        logic [255:0] o;
        int           sh [4];
        int           k;
        o = '0;
        if (nb == 8) sh = '{0, 1, 3, 4};
        else         sh = '{0, 1, 2, 3};
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[8*(4*c+r) +: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++) begin
                k = inv ? c - sh[r] : c + sh[r];
                k = ((k % nb) + nb) % nb;
                o[8*(4*c+r) +: 8] = st[r][k];
            end
        return o;
    endfunction

    function automatic logic [255:0] seq_bytes(input int n);
        logic [255:0] b;
        b = '0;
        for (int i = 0; i < n; i++)
            b[8*i +: 8] = i[7:0];
        return b;
    endfunction

    task automatic checkd(input string tag, input logic [255:0] obs,
                          input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs,
                          input logic exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One bus4 cycle: drive, check against model, clock, update model.
    task automatic cycle(input logic v, input logic inv,
                         input logic [127:0] d, input logic ordy,
                         input logic fl);
        logic         exp_rdy;
        logic         do_push;
        logic         do_pop;
        logic [255:0] t;
        exp_t         e;
        bus4.in_valid  = v;
        bus4.in_inv    = inv;
        bus4.in_data   = d;
        bus4.out_ready = ordy;
        flush          = fl;
        #1;
        exp_rdy = (q.size() < 2) && !fl;
        check1("in_ready", bus4.in_ready, exp_rdy);
        check1("out_valid", bus4.out_valid, q.size() > 0);
        if (q.size() > 0) begin
            checkd("out_data", 256'(bus4.out_data), 256'(q[0].data));
            check1("out_inv", bus4.out_inv, q[0].inv);
        end
        do_push = v && exp_rdy;
        do_pop  = (q.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop)
                e = q.pop_front();
            if (do_push) begin
                t      = ref_shift(256'(d), inv, 4);
                e.inv  = inv;
                e.data = t[127:0];
                q.push_back(e);
            end
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [127:0] fwd_vec;
    logic [255:0] ob;

    initial begin
        fwd_vec = 128'h0b06010c07020d08030e09040f0a0500;
        bus4.in_valid  = 1'b0;
        bus4.in_inv    = 1'b0;
        bus4.in_data   = '0;
        bus4.out_ready = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.in_inv    = 1'b0;
        bus8.in_data   = '0;
        bus8.out_ready = 1'b0;

        #2;
        check1("rst_out_valid", bus4.out_valid, 1'b0);
        check1("rst_in_ready", bus4.in_ready, 1'b0);
        checkd("rst_out_data", 256'(bus4.out_data), '0);
        check1("rst_out_inv", bus4.out_inv, 1'b0);
        check1("rst8_out_valid", bus8.out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("post_rst_in_ready", bus4.in_ready, 1'b1);
        check1("post_rst8_in_ready", bus8.in_ready, 1'b1);

        // NB=8 forward vector
        bus8.in_valid = 1'b1;
        bus8.in_data  = seq_bytes(32);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        ob = bus8.out_data;
        check1("nb8_out_valid", bus8.out_valid, 1'b1);
        checkd("nb8_r2c0", 256'(ob[8*2 +: 8]), 256'(8'h0e));
        checkd("nb8_r3c0", 256'(ob[8*3 +: 8]), 256'(8'h13));
        checkd("nb8_r1c7", 256'(ob[8*29 +: 8]), 256'(8'h01));
        checkd("nb8_full", ob, ref_shift(seq_bytes(32), 1'b0, 8));
        check1("nb8_out_inv", bus8.out_inv, 1'b0);
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check1("nb8_drained", bus8.out_valid, 1'b0);

        // NB=4 forward vector, then inverse back
        cycle(1'b1, 1'b0, seq_bytes(16), 1'b0, 1'b0);
        checkd("fwd_vec", 256'(bus4.out_data), 256'(fwd_vec));
        check1("fwd_inv_tag", bus4.out_inv, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, fwd_vec, 1'b0, 1'b0);
        checkd("inv_vec", 256'(bus4.out_data), seq_bytes(16));
        check1("inv_inv_tag", bus4.out_inv, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // backpressure: 3 offered, 2 accepted, hold, then drain
        repeat (3)
            cycle(1'b1, 1'($urandom_range(0, 1)), rnd128(), 1'b0, 1'b0);
        check1("full_in_ready", bus4.in_ready, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (3)
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // count=1 with simultaneous push/pop, alternating mode
        cycle(1'b1, 1'b0, rnd128(), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 1'(i % 2), rnd128(), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // flush at count=2 with same-cycle push and pop
        cycle(1'b1, 1'b0, rnd128(), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, rnd128(), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, rnd128(), 1'b1, 1'b1);
        flush = 1'b0;
        bus4.in_valid = 1'b0;
        #1;
        check1("flush_out_valid", bus4.out_valid, 1'b0);
        check1("flush_in_ready", bus4.in_ready, 1'b1);

        // reset mid-stream
        cycle(1'b1, 1'b1, rnd128(), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, rnd128(), 1'b0, 1'b0);
        rst_n = 1'b0;
        bus4.in_valid = 1'b0;
        #1;
        check1("mid_rst_out_valid", bus4.out_valid, 1'b0);
        check1("mid_rst_in_ready", bus4.in_ready, 1'b0);
        checkd("mid_rst_out_data", 256'(bus4.out_data), '0);
        check1("mid_rst_out_inv", bus4.out_inv, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        check1("rel_in_ready", bus4.in_ready, 1'b1);
        check1("rel_out_valid", bus4.out_valid, 1'b0);

        // random traffic
        repeat (300)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  rnd128(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0);
        repeat (3)
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end
endmodule
